sdrc_wb_burst_master: RTL and testbench
=======================================

Name: sdrc_wb_burst_master

Overview:
Wishbone burst master that sits directly upstream of the SDRAM controller's Wishbone slave port (wb_* signals of sdrc_top).
- Accepts one command at a time: read or write, start byte address, beat count.
- Runs the command as an incrementing Wishbone burst: CTI 3'b010, last beat 3'b111.
- Streams write data in and read data out.
- Serves as the bus front-end for the verification traffic generator and for future on-chip clients.

Parameters:
DW, 32, Wishbone data width in bits (multiple of 8)
AW, 26, Wishbone byte-address width
LW, 8, width of cmd_len (max burst = 2**LW beats)
TO_CYC, 1023, cycles without wb_ack_i during an active strobe before abort (TO_CYC >= 1)

Ports:
wb_clk_i  in  1  clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1=write burst, 0=read burst
cmd_addr  in  AW  start byte address, DW/8 aligned
cmd_len  in  LW  beats minus one
wr_data  in  DW  write stream data
wr_valid  in  1  write data available
wr_ready  out  1  write beat consumed when wr_valid & wr_ready
rd_data  out  DW  read stream data
rd_valid  out  1  read beat valid, one cycle, no backpressure
done  out  1  one-cycle pulse, command finished (normal or abort)
err  out  1  one-cycle pulse coincident with done on timeout abort
busy  out  1  state != IDLE
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_addr_o  out  AW  Wishbone byte address
wb_dat_o  out  DW  Wishbone write data
wb_sel_o  out  DW/8  byte selects, always all ones
wb_cti_o  out  3  cycle type identifier
wb_ack_i  in  1  Wishbone acknowledge
wb_dat_i  in  DW  Wishbone read data

Behaviour:
Reset:
- All outputs 0, except wb_sel_o which is all ones.
- State IDLE, counters 0, data register empty.
- Assertion mid-burst drops wb_cyc_o/wb_stb_o immediately (asynchronously). No done pulse.

State machine IDLE -> XFER -> FIN -> IDLE:
- IDLE: cmd_ready=1. On accept, latch we, addr, len into registers: beats_left=len, fetch_left=len. Go to XFER. wb_cyc_o rises the next cycle.
- XFER:
  - wb_cyc_o=1 for the whole state.
  - Reads: wb_stb_o=1 throughout.
  - Writes: wb_stb_o = data register valid.
- FIN: cyc=stb=0. done=1 for one cycle. Return to IDLE. cmd_ready stays 0 in FIN, so the minimum command-to-command spacing is 1 idle cycle.

Beats:
- Each cycle with stb & wb_ack_i completes one beat.
- On each completed beat: wb_addr_o += DW/8, wrapping modulo 2**AW, and beats_left decrements.
- Ack on the final beat (beats_left==0) moves the state to FIN.
- wb_cti_o = 3'b010 while beats_left>0, 3'b111 when beats_left==0. A single-beat command (len 0) uses 3'b111.
- wb_cti_o = 3'b000 outside XFER.

Write data:
- One-entry register feeds wb_dat_o.
- wr_ready = XFER & we & fetch_cnt_ok & (!dreg_vld | (stb & wb_ack_i)). This allows back-to-back beats with zero bubbles.
- If wr_valid is low, stb deasserts (wait state). cyc, addr and cti hold.
- Exactly len+1 wr beats are consumed per write command.

Read data:
- rd_data=wb_dat_i and rd_valid=1 are registered one cycle after each ack.
- The last rd_valid coincides with done.

Timeout:
- Counter resets on every ack and whenever stb is low. It increments while stb=1 & !ack.
- When it reaches TO_CYC, go to FIN with err=1.
- On a write abort, unconsumed write data is not requested and the data register is cleared.

Other rules:
- wb_ack_i while stb=0 is ignored.
- cmd_valid is ignored while not IDLE.

Decomposition:
Package sdrc_wbm_pkg holds:
- CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
- State enum {IDLE, XFER, FIN}.

No sub-module: a single RTL file of about 200 lines.

Test Plan:
- Write: cmd_we=1, addr=0x100, len=3, wr_data 0xA0..0xA3 always valid, ack every cycle → addresses 0x100, 0x104, 0x108, 0x10C; cti 010, 010, 010, 111; done 1 cycle after last ack; no stb gap.
- Read back same range via sdrc_top + SDRAM model → rd_data 0xA0..0xA3 in order, 4 rd_valid pulses, last one with done, err=0.
- Write stall: wr_valid low 3 cycles before beat 2 → stb low 3 cycles, cyc high, wb_addr_o holds 0x104, cti holds 010, beat count still 4.
- Single beat: len=0, addr=0x3FFFFFC → cti 111 on the only beat; addr wrap check: len=1 at 0x3FFFFFC → second addr 0x0000000.
- Timeout: TO_CYC=8, ack never asserted → stb high exactly 8 cycles, then cyc=0, done=1 and err=1 same cycle, next command accepted.
- Reset mid-burst: resetn low during beat 2 of len=7 → cyc/stb/cti 0 immediately, done never pulses, cmd_ready=1 after release.

Source files
------------

// File: rtl/sdrc_wbm_pkg.sv
// ---------------------------------------------------------------------------
// sdrc_wbm_pkg
//   Shared definitions for the Wishbone burst master that fronts the SDRAM
//   controller's Wishbone slave port.
//   Contents:
//     CTI_CLASSIC / CTI_INCR / CTI_EOB  Wishbone cycle type identifiers
//     wbm_state_e                       burst master FSM states
// ---------------------------------------------------------------------------
package sdrc_wbm_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } wbm_state_e;

endpackage : sdrc_wbm_pkg

// File: rtl/sdrc_wb_burst_master.sv
// ---------------------------------------------------------------------------
// sdrc_wb_burst_master
//   Runs one read or write command at a time as an incrementing Wishbone
//   burst towards the SDRAM controller. Write data is streamed in through a
//   one-entry data register, read data is streamed out one cycle after each
//   acknowledge. A strobe that waits TO_CYC cycles without an acknowledge
//   aborts the command with an error pulse.
//
//   Ports:
//     wb_clk_i, resetn        clock (rising edge), async active-low reset
//     cmd_valid/cmd_ready     command handshake (accepted only in IDLE)
//     cmd_we/addr/len         direction, start byte address, beats minus one
//     wr_data/valid/ready     write data stream into the master
//     rd_data/rd_valid        read data stream out (no backpressure)
//     done, err, busy         completion pulse, abort pulse, activity flag
//     wb_*                    Wishbone master interface
// ---------------------------------------------------------------------------
module sdrc_wb_burst_master
  import sdrc_wbm_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 26,
  parameter int LW     = 8,
  parameter int TO_CYC = 1023
) (
  input  logic            wb_clk_i,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW-1:0]   wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int            TW        = $clog2(TO_CYC + 1);
  localparam logic [AW-1:0] ADDR_STEP = AW'(DW / 8);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  wbm_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] beats_q, beats_d;
  logic [LW-1:0] fetch_q, fetch_d;
  logic          fetch_all_q, fetch_all_d;
  logic [DW-1:0] dreg_q, dreg_d;
  logic          dreg_vld_q, dreg_vld_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic stb;
  logic wr_rdy;
  logic beat;
  logic fetch;
  logic accept;
  logic timeout;
  logic last_beat;

  // Writes only strobe while a data word is staged; reads strobe throughout.
  // The data register refills in the same cycle its word is acknowledged,
  // which keeps write beats back to back. fetch_all_q stops requests once
  // len+1 words have been taken.
  assign stb       = (state_q == XFER) && (!we_q || dreg_vld_q);
  assign wr_rdy    = (state_q == XFER) && we_q && !fetch_all_q &&
                     (!dreg_vld_q || (stb && wb_ack_i));
  assign beat      = stb && wb_ack_i;
  assign fetch     = wr_valid && wr_rdy;
  assign accept    = cmd_valid && (state_q == IDLE);
  assign last_beat = beat && (beats_q == '0);
  // The counter value is compared one short of TO_CYC so the strobe is high
  // for exactly TO_CYC cycles before FIN is entered.
  assign timeout   = stb && !wb_ack_i && (to_cnt_q == TO_LAST);

  // State and datapath registers; reset pulls cyc/stb low immediately since
  // they are decoded from state_q.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      beats_q     <= '0;
      fetch_q     <= '0;
      fetch_all_q <= 1'b0;
      dreg_q      <= '0;
      dreg_vld_q  <= 1'b0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      fetch_q     <= fetch_d;
      fetch_all_q <= fetch_all_d;
      dreg_q      <= dreg_d;
      dreg_vld_q  <= dreg_vld_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Next state: a burst ends on the final acknowledge or on a timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = XFER;
      XFER:    if (last_beat || timeout) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: command latch, beat bookkeeping, write staging,
  // timeout counting and read capture.
  always_comb begin
    we_d        = we_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    fetch_d     = fetch_q;
    fetch_all_d = fetch_all_q;
    dreg_d      = dreg_q;
    dreg_vld_d  = dreg_vld_q;
    to_cnt_d    = '0;
    err_d       = timeout;
    rd_data_d   = rd_data_q;
    rd_valid_d  = beat && !we_q;

    if (accept) begin
      we_d        = cmd_we;
      addr_d      = cmd_addr;
      beats_d     = cmd_len;
      fetch_d     = cmd_len;
      fetch_all_d = 1'b0;
    end

    if (beat) begin
      addr_d = addr_q + ADDR_STEP;
      if (beats_q != '0) beats_d = beats_q - 1'b1;
      if (we_q) dreg_vld_d = 1'b0;
      else      rd_data_d  = wb_dat_i;
    end

    if (fetch) begin
      dreg_d     = wr_data;
      dreg_vld_d = 1'b1;
      if (fetch_q == '0) fetch_all_d = 1'b1;
      else               fetch_d     = fetch_q - 1'b1;
    end

    if (stb && !wb_ack_i) to_cnt_d = to_cnt_q + 1'b1;

    // A staged word left over from an aborted write is discarded.
    if (state_q != XFER) dreg_vld_d = 1'b0;
  end

  // Output decode from the current state and registers.
  always_comb begin
    cmd_ready = (state_q == IDLE) && resetn;
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    err       = err_q;
    wr_ready  = wr_rdy;
    rd_data   = rd_data_q;
    rd_valid  = rd_valid_q;
    wb_cyc_o  = (state_q == XFER);
    wb_stb_o  = stb;
    wb_we_o   = (state_q == XFER) && we_q;
    wb_addr_o = addr_q;
    wb_dat_o  = dreg_q;
    wb_sel_o  = '1;
    wb_cti_o  = CTI_CLASSIC;
    if (state_q == XFER) wb_cti_o = (beats_q == '0) ? CTI_EOB : CTI_INCR;
  end

endmodule : sdrc_wb_burst_master

// File: tb/tb_sdrc_wb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_sdrc_wb_burst_master
//   Directed bench for the Wishbone burst master with a small memory-backed
//   slave whose acknowledge can be enabled or withheld.
// ---------------------------------------------------------------------------
module tb_sdrc_wb_burst_master;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [25:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        busy;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  logic        ack_en;
  logic [31:0] mem [256];

  int checks   = 0;
  int failures = 0;

  // Results gathered by run_xfer
  int          n_beats, n_rd, n_wr, stb_cyc, gap_n, done_cyc, last_ack_cyc;
  int          done_cnt, err_cnt;
  bit          got_done, err_at_done, cyc_at_done, rdv_at_done, acc_rdy;
  logic [25:0] b_addr [16];
  logic [2:0]  b_cti  [16];
  logic [31:0] b_dat  [16];
  logic [31:0] rd_seq [16];
  logic [25:0] gap_addr [8];
  logic [2:0]  gap_cti  [8];

  sdrc_wb_burst_master #(.DW(32), .AW(26), .LW(8), .TO_CYC(8)) dut (
    .wb_clk_i (clk),       .resetn   (resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),    .cmd_addr (cmd_addr),  .cmd_len(cmd_len),
    .wr_data  (wr_data),   .wr_valid (wr_valid),  .wr_ready(wr_ready),
    .rd_data  (rd_data),   .rd_valid (rd_valid),
    .done     (done),      .err      (err),       .busy(busy),
    .wb_cyc_o (wb_cyc_o),  .wb_stb_o (wb_stb_o),  .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o (wb_dat_o),  .wb_sel_o(wb_sel_o),
    .wb_cti_o (wb_cti_o),  .wb_ack_i (wb_ack_i),  .wb_dat_i(wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait slave: acknowledges every strobe while enabled.
  assign wb_ack_i = ack_en && wb_cyc_o && wb_stb_o;
  assign wb_dat_i = mem[wb_addr_o[9:2]];

  always @(posedge clk)
    if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i)
      mem[wb_addr_o[9:2]] <= wb_dat_o;

  task automatic send_cmd(input bit we, input logic [25:0] a, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    acc_rdy = cmd_ready;
  endtask

  // Drives the write stream and slave acknowledge, recording what the bus did
  // each cycle; cycle 1 is the first cycle after command acceptance.
  task automatic run_xfer(input int max_cyc, input logic [31:0] wbase,
                          input int stall_at, input int stall_n, input bit ack_on);
    int  widx, stall_left;
    bit  stalled, first_stb;
    widx = 0; stall_left = 0; stalled = 0; first_stb = 0;
    n_beats = 0; n_rd = 0; n_wr = 0; stb_cyc = 0; gap_n = 0;
    done_cyc = 0; last_ack_cyc = 0; done_cnt = 0; err_cnt = 0;
    got_done = 0; err_at_done = 0; cyc_at_done = 0; rdv_at_done = 0;
    for (int c = 1; c <= max_cyc && !got_done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!stalled && stall_n > 0 && widx == stall_at) begin
        stall_left = stall_n;
        stalled    = 1;
      end
      wr_valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      wr_data = wbase + 32'(widx);
      ack_en  = ack_on;
      #1;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && n_beats < 16) begin
        b_addr[n_beats] = wb_addr_o;
        b_cti[n_beats]  = wb_cti_o;
        b_dat[n_beats]  = wb_dat_o;
        n_beats++;
        last_ack_cyc = c;
      end
      if (wb_stb_o) begin
        stb_cyc++;
        first_stb = 1;
      end else if (wb_cyc_o && first_stb && gap_n < 8) begin
        gap_addr[gap_n] = wb_addr_o;
        gap_cti[gap_n]  = wb_cti_o;
        gap_n++;
      end
      if (wr_valid && wr_ready) begin
        widx++;
        n_wr++;
      end
      if (rd_valid && n_rd < 16) begin
        rd_seq[n_rd] = rd_data;
        n_rd++;
      end
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        got_done    = 1;
        done_cyc    = c;
        err_at_done = err;
        cyc_at_done = wb_cyc_o;
        rdv_at_done = rd_valid;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      if (done) done_cnt++;
      if (rd_valid) n_rd++;
      if (err) err_cnt++;
    end
    wr_valid = 1'b0;
    ack_en   = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o} !== 6'b0) begin
      failures++; $display("FAIL reset_bus got=%b exp=0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o});
    end
    checks++;
    if ({done, err, busy, rd_valid, wr_ready} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {done, err, busy, rd_valid, wr_ready});
    end
    checks++;
    if (wb_addr_o !== 26'h0 || wb_dat_o !== 32'h0) begin
      failures++; $display("FAIL reset_addr_dat got=%h/%h exp=0/0", wb_addr_o, wb_dat_o);
    end
    checks++;
    if (wb_sel_o !== 4'hF) begin failures++; $display("FAIL reset_sel got=%h exp=f", wb_sel_o); end
    resetn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write;
    logic [25:0] ea [4];
    logic [2:0]  ec [4];
    ea = '{26'h100, 26'h104, 26'h108, 26'h10C};
    ec = '{3'b010, 3'b010, 3'b010, 3'b111};
    send_cmd(1'b1, 26'h100, 8'd3);
    checks++;
    if (acc_rdy !== 1'b1) begin failures++; $display("FAIL wr_accept got=%b exp=1", acc_rdy); end
    run_xfer(20, 32'hA0, 0, 0, 1'b1);
    checks++;
    if (n_beats !== 4 || n_wr !== 4) begin
      failures++; $display("FAIL wr_counts beats=%0d wr=%0d exp=4/4", n_beats, n_wr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_addr[i] !== ea[i] || b_cti[i] !== ec[i] || b_dat[i] !== 32'hA0 + 32'(i)) begin
        failures++;
        $display("FAIL wr_beat%0d got=%h/%b/%h exp=%h/%b/%h", i, b_addr[i], b_cti[i], b_dat[i],
                 ea[i], ec[i], 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (done_cyc !== 6 || last_ack_cyc !== 5) begin
      failures++; $display("FAIL wr_done_timing done=%0d ack=%0d exp=6/5", done_cyc, last_ack_cyc);
    end
    checks++;
    if (gap_n !== 0 || stb_cyc !== 4) begin
      failures++; $display("FAIL wr_no_gap gaps=%0d stb=%0d exp=0/4", gap_n, stb_cyc);
    end
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      failures++; $display("FAIL wr_done_err done=%0d err=%0d exp=1/0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_read;
    send_cmd(1'b0, 26'h100, 8'd3);
    run_xfer(20, 32'h0, 0, 0, 1'b1);
    checks++;
    if (n_rd !== 4) begin failures++; $display("FAIL rd_count got=%0d exp=4", n_rd); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_seq[i] !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL rd_data%0d got=%h exp=%h", i, rd_seq[i], 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (done_cyc !== 5 || rdv_at_done !== 1'b1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL rd_done done=%0d rdv=%b err=%0d exp=5/1/0", done_cyc, rdv_at_done, err_cnt);
    end
  endtask

  task automatic test_write_stall;
    send_cmd(1'b1, 26'h100, 8'd3);
    run_xfer(30, 32'hB0, 1, 3, 1'b1);
    checks++;
    if (gap_n !== 3) begin failures++; $display("FAIL stall_gap got=%0d exp=3", gap_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gap_addr[i] !== 26'h104 || gap_cti[i] !== 3'b010) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%b exp=104/010", i, gap_addr[i], gap_cti[i]);
      end
    end
    checks++;
    if (n_beats !== 4 || n_wr !== 4 || b_addr[3] !== 26'h10C || b_dat[3] !== 32'hB3) begin
      failures++;
      $display("FAIL stall_beats beats=%0d wr=%0d last=%h/%h exp=4/4/10c/b3", n_beats, n_wr, b_addr[3], b_dat[3]);
    end
    checks++;
    if (done_cyc !== 9 || done_cnt !== 1) begin
      failures++; $display("FAIL stall_done cyc=%0d cnt=%0d exp=9/1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_single_and_wrap;
    send_cmd(1'b1, 26'h3FFFFFC, 8'd0);
    run_xfer(10, 32'hC0, 0, 0, 1'b1);
    checks++;
    if (n_beats !== 1 || b_cti[0] !== 3'b111 || b_addr[0] !== 26'h3FFFFFC || n_wr !== 1) begin
      failures++;
      $display("FAIL single_beat beats=%0d cti=%b addr=%h wr=%0d exp=1/111/3fffffc/1", n_beats, b_cti[0], b_addr[0], n_wr);
    end
    send_cmd(1'b1, 26'h3FFFFFC, 8'd1);
    run_xfer(10, 32'hD0, 0, 0, 1'b1);
    checks++;
    if (n_beats !== 2 || b_addr[1] !== 26'h0 || b_cti[0] !== 3'b010 || b_cti[1] !== 3'b111) begin
      failures++;
      $display("FAIL addr_wrap beats=%0d addr1=%h cti=%b/%b exp=2/0/010/111", n_beats, b_addr[1], b_cti[0], b_cti[1]);
    end
    checks++;
    if (mem[0] !== 32'hD1 || mem[255] !== 32'hD0) begin
      failures++; $display("FAIL wrap_mem got=%h/%h exp=d1/d0", mem[0], mem[255]);
    end
  endtask

  task automatic test_timeout;
    send_cmd(1'b0, 26'h100, 8'd3);
    run_xfer(20, 32'h0, 0, 0, 1'b0);
    checks++;
    if (stb_cyc !== 8) begin failures++; $display("FAIL to_stb_cycles got=%0d exp=8", stb_cyc); end
    checks++;
    if (done_cyc !== 9 || err_at_done !== 1'b1 || cyc_at_done !== 1'b0) begin
      failures++;
      $display("FAIL to_abort done=%0d err=%b cyc=%b exp=9/1/0", done_cyc, err_at_done, cyc_at_done);
    end
    checks++;
    if (err_cnt !== 1 || done_cnt !== 1 || n_rd !== 0) begin
      failures++; $display("FAIL to_pulses err=%0d done=%0d rd=%0d exp=1/1/0", err_cnt, done_cnt, n_rd);
    end
    send_cmd(1'b0, 26'h100, 8'd0);
    checks++;
    if (acc_rdy !== 1'b1) begin failures++; $display("FAIL to_next_accept got=%b exp=1", acc_rdy); end
    run_xfer(10, 32'h0, 0, 0, 1'b1);
    checks++;
    if (!got_done || err_at_done !== 1'b0 || n_rd !== 1 || rd_seq[0] !== 32'hB0) begin
      failures++;
      $display("FAIL to_next_cmd done=%b err=%b rd=%0d data=%h exp=1/0/1/b0", got_done, err_at_done, n_rd, rd_seq[0]);
    end
  endtask

  task automatic test_reset_mid_burst;
    int dcnt, ccnt;
    send_cmd(1'b0, 26'h100, 8'd7);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      ack_en    = 1'b1;
      #1;
    end
    checks++;
    if (!(wb_stb_o && wb_ack_i) || wb_addr_o !== 26'h108) begin
      failures++; $display("FAIL mid_setup stb=%b ack=%b addr=%h exp=1/1/108", wb_stb_o, wb_ack_i, wb_addr_o);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_cti_o, busy, done} !== 7'b0) begin
      failures++; $display("FAIL mid_async_drop got=%b exp=0", {wb_cyc_o, wb_stb_o, wb_cti_o, busy, done});
    end
    @(negedge clk);
    resetn = 1'b1;
    ack_en = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", cmd_ready); end
    dcnt = 0; ccnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) dcnt++;
      if (wb_cyc_o) ccnt++;
    end
    checks++;
    if (dcnt !== 0 || ccnt !== 0) begin
      failures++; $display("FAIL mid_no_done done=%0d cyc=%0d exp=0/0", dcnt, ccnt);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; ack_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_write_stall();
    test_single_and_wrap();
    test_timeout();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_sdrc_wb_burst_master
